// File: rtl/target_track_controller_if.sv
// Signal bundle between the detector/operator/actuator side and the tracking controller.
// The master side drives frame and fire inputs; the controller (slave) returns status.
interface target_track_controller_if;
    logic       frame_end;
    logic       object_detected;
    logic       fire_req;
    logic       fire_ack;
    logic       fire_cmd;
    logic       on_screen;
    logic       locked;
    logic [2:0] state;

    modport master (
        output frame_end, object_detected, fire_req, fire_ack,
        input  fire_cmd, on_screen, locked, state
    );

    modport slave (
        input  frame_end, object_detected, fire_req, fire_ack,
        output fire_cmd, on_screen, locked, state
    );
endinterface

// File: rtl/target_track_controller.sv
// Frame-level target acquisition, coast-through-dropout and single-shot fire sequencing.
// Every output is a flop loaded from the decoded next state, so no input reaches an output combinationally.
module target_track_controller #(
    parameter int clock_frequency_mhz        = 50,
    parameter int acquire_frames             = 4,
    parameter int coast_time_milliseconds    = 1000,
    parameter int cooldown_time_milliseconds = 500
) (
    input  logic                     clk,
    input  logic                     rst,
    target_track_controller_if.slave bus
);
    localparam int coast_cycles_c    = clock_frequency_mhz * 1000 * coast_time_milliseconds;
    localparam int cooldown_cycles_c = clock_frequency_mhz * 1000 * cooldown_time_milliseconds;
    localparam int max_cycles_c      = (coast_cycles_c > cooldown_cycles_c) ? coast_cycles_c : cooldown_cycles_c;
    localparam int timer_w_c         = ($clog2(max_cycles_c) < 1) ? 1 : $clog2(max_cycles_c);

    localparam logic [timer_w_c-1:0] coast_last_c    = timer_w_c'(coast_cycles_c - 1);
    localparam logic [timer_w_c-1:0] cooldown_last_c = timer_w_c'(cooldown_cycles_c - 1);
    localparam logic [3:0]           acquire_c       = 4'(acquire_frames);

    typedef enum logic [2:0] {
        st_idle     = 3'd0,
        st_acquire  = 3'd1,
        st_locked   = 3'd2,
        st_coast    = 3'd3,
        st_fire     = 3'd4,
        st_cooldown = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [timer_w_c-1:0]   timer_r;
    logic [3:0]             hit_cnt_r;
    logic [3:0]             hit_cnt_s;
    logic                   seen_acc_r;
    logic                   last_hit_r;
    logic                   frame_hit_s;
    logic                   fire_cmd_r;
    logic                   on_screen_r;
    logic                   locked_r;

    // A detection in the frame_end cycle itself still belongs to the closing frame.
    assign frame_hit_s = seen_acc_r | bus.object_detected;

    // Next-state and acquisition counter decode.
    always_comb begin
        next_state_s = state_r;
        hit_cnt_s    = hit_cnt_r;
        case (state_r)
            st_idle: begin
                if (bus.frame_end && frame_hit_s) begin
                    hit_cnt_s    = 4'd1;
                    next_state_s = (acquire_c == 4'd1) ? st_locked : st_acquire;
                end else begin
                    next_state_s = st_idle;
                end
            end
            st_acquire: begin
                if (bus.frame_end && frame_hit_s) begin
                    hit_cnt_s    = hit_cnt_r + 4'd1;
                    next_state_s = ((hit_cnt_r + 4'd1) == acquire_c) ? st_locked : st_acquire;
                end else if (bus.frame_end) begin
                    hit_cnt_s    = 4'd0;
                    next_state_s = st_idle;
                end else begin
                    next_state_s = st_acquire;
                end
            end
            st_locked: begin
                hit_cnt_s = 4'd0;
                if (bus.fire_req) begin
                    next_state_s = st_fire;
                end else if (bus.frame_end && !frame_hit_s) begin
                    next_state_s = st_coast;
                end else begin
                    next_state_s = st_locked;
                end
            end
            st_coast: begin
                hit_cnt_s = 4'd0;
                if (bus.frame_end && frame_hit_s) begin
                    next_state_s = st_locked;
                end else if (timer_r == coast_last_c) begin
                    next_state_s = st_idle;
                end else begin
                    next_state_s = st_coast;
                end
            end
            st_fire: begin
                hit_cnt_s = 4'd0;
                if (bus.fire_ack) begin
                    next_state_s = st_cooldown;
                end else begin
                    next_state_s = st_fire;
                end
            end
            st_cooldown: begin
                hit_cnt_s = 4'd0;
                if (timer_r == cooldown_last_c) begin
                    next_state_s = last_hit_r ? st_locked : st_coast;
                end else begin
                    next_state_s = st_cooldown;
                end
            end
            default: begin
                hit_cnt_s    = 4'd0;
                next_state_s = st_idle;
            end
        endcase
    end

    // State, shared timer, frame accumulators and registered output decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= st_idle;
            timer_r     <= '0;
            hit_cnt_r   <= 4'd0;
            seen_acc_r  <= 1'b0;
            last_hit_r  <= 1'b0;
            fire_cmd_r  <= 1'b0;
            on_screen_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            hit_cnt_r  <= hit_cnt_s;
            seen_acc_r <= bus.frame_end ? 1'b0 : (seen_acc_r | bus.object_detected);
            if (bus.frame_end) begin
                last_hit_r <= frame_hit_s;
            end
            // Any state change restarts the timer, so COAST/COOLDOWN always begin at zero.
            if (next_state_s != state_r) begin
                timer_r <= '0;
            end else begin
                timer_r <= timer_r + timer_w_c'(1);
            end
            fire_cmd_r  <= (next_state_s == st_fire);
            on_screen_r <= (next_state_s == st_locked) || (next_state_s == st_coast) ||
                           (next_state_s == st_fire)   || (next_state_s == st_cooldown);
            locked_r    <= (next_state_s == st_locked) || (next_state_s == st_fire) ||
                           (next_state_s == st_cooldown);
        end
    end

    assign bus.state     = state_r;
    assign bus.fire_cmd  = fire_cmd_r;
    assign bus.on_screen = on_screen_r;
    assign bus.locked    = locked_r;
endmodule

// File: doc/target_track_controller.md
# target_track_controller

Frame-level tracking and fire-sequencing controller between the object detector and the launcher actuator. Accumulates per-frame detection results and requires a configurable run of consecutive detected frames before declaring lock. It coasts through short dropouts for a fixed hold time and grants a single fire command per operator request through a valid/ack handshake, followed by a cooldown. All outputs decode from a registered state; no combinational input-to-output path.

## Interface
- clock_frequency_mhz, 50: clock rate; timer cycles = clock_frequency_mhz * 1000 * ms
- acquire_frames, 4: consecutive detected frames required to lock; legal range 1..15
- coast_time_milliseconds, 1000: hold time after track loss before dropping to IDLE
- cooldown_time_milliseconds, 500: dead time after each fire acknowledge
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- frame_end  input  1  one-cycle strobe marking the last cycle of a video frame
- object_detected  input  1  detector hit, level, any cycle within a frame
- fire_req  input  1  operator fire request, level
- fire_ack  input  1  actuator acknowledge, one cycle
- fire_cmd  output  1  fire valid; held until fire_ack
- on_screen  output  1  target currently tracked or coasting
- locked  output  1  target lock confirmed
- state  output  3  current state encoding, for debug/LEDs

## Operation
- seen_acc: sticky flag, set by object_detected, cleared on frame_end. frame_hit = seen_acc | object_detected, evaluated on the frame_end cycle.
- last_hit: register loaded with frame_hit on every frame_end in every state.
- hit_cnt: 4-bit counter, used only in IDLE/ACQUIRE.
- One shared timer, counting up from 0. Width is $clog2 of the larger cycle count. It expires when count == N-1, so a state is resident exactly N cycles if not preempted.
- States and encodings: IDLE=0, ACQUIRE=1, LOCKED=2, COAST=3, FIRE=4, COOLDOWN=5. Encodings 6 and 7 go to IDLE on the next cycle.
- IDLE:
  - frame_end & frame_hit -> ACQUIRE with hit_cnt=1.
  - If acquire_frames==1, go directly to LOCKED instead.
- ACQUIRE:
  - frame_end & frame_hit -> hit_cnt+1; go to LOCKED when the new count equals acquire_frames.
  - frame_end & !frame_hit -> IDLE, hit_cnt=0.
- LOCKED:
  - fire_req -> FIRE.
  - Otherwise, frame_end & !frame_hit -> COAST, timer cleared.
- COAST:
  - frame_end & frame_hit -> LOCKED. This takes priority over timer expiry in the same cycle.
  - Coast timer expiry -> IDLE.
  - fire_req is ignored.
- FIRE:
  - fire_cmd=1.
  - fire_ack -> COOLDOWN, timer cleared.
  - frame_end only updates last_hit.
- COOLDOWN:
  - On cooldown timer expiry, go to LOCKED if last_hit=1, else COAST with timer cleared.
  - fire_req is ignored.
  - A level still high at re-entry to LOCKED fires again.
- Output decode:
  - on_screen = LOCKED | COAST | FIRE | COOLDOWN.
  - locked = LOCKED | FIRE | COOLDOWN.
  - fire_cmd = FIRE.
- fire_ack outside FIRE is ignored.

## Timing
- Reset values: state=IDLE(0), fire_cmd=0, on_screen=0, locked=0, seen_acc=0, last_hit=0, hit_cnt=0, timer=0.
- rst asserted mid-operation forces these values immediately (asynchronous), including dropping fire_cmd mid-handshake.
- Latency: an event sampled at clock edge t is reflected on outputs after edge t (visible in cycle t+1).
- Lock latency from IDLE: acquire_frames frame_end strobes with frame_hit=1. locked rises in the cycle after the last of these strobes.
- fire_cmd rises the cycle after fire_req is sampled in LOCKED. It stays high until the edge sampling fire_ack, then is low the following cycle.
- Same-cycle priorities:
  - LOCKED: fire_req beats loss-frame.
  - COAST: hit-frame beats expiry.
  - FIRE: fire_ack and frame_end are both processed.
- object_detected high in the frame_end cycle counts toward the closing frame, not the next one.
- Cooldown residency is exactly cooldown cycles. Coast residency is exactly coast cycles absent a hit.

## Test plan
Bench parameters: clock_frequency_mhz=1, acquire_frames=3, coast=2 ms (2000 cycles), cooldown=1 ms (1000 cycles).

- Lock: 3 frames each with one object_detected pulse -> state 1,1,2; locked=1 one cycle after the 3rd frame_end. Hit, hit, miss -> back to IDLE, hit_cnt=0.
- Coast recovery: locked, then a miss frame -> state=3, on_screen=1, locked=0. A hit frame at cycle 1500 -> LOCKED. A hit frame_end coincident with cycle 1999 -> LOCKED, not IDLE.
- Coast expiry: locked, a miss frame, then no hits -> IDLE exactly 2000 cycles after entering COAST; on_screen=0.
- Fire handshake: locked, fire_req=1 -> fire_cmd=1 next cycle. Withhold ack 50 cycles -> fire_cmd stays 1. Send ack -> fire_cmd=0 next cycle, state=5, then 1000 cycles later LOCKED if last_hit=1, else COAST.
- Priority/ignore: fire_req with a miss frame_end same cycle in LOCKED -> FIRE. fire_req in COAST or COOLDOWN -> no fire_cmd. Stray fire_ack in LOCKED -> no change.
- Reset: assert rst while fire_cmd=1 -> fire_cmd, locked and on_screen go 0 immediately, state=0. After release, 3 hit frames relock.
